mem_arbiter: RTL and testbench

//  Two-master arbiter for the unified instruction/data memory. Master 0 is the multicycle

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arb_prio.sv | 99 +++++++++
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-master unified-memory arbiter.
// Master 0 is the CPU, master 1 is the DMA/boot-loader port.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        PRI_CPU = 1'b0,
        PRI_DMA = 1'b1
    } pri_state_t;

    // Encoding of the granted master as it travels down the access pipeline.
    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response bundle for one requester of the memory arbiter.
// "master" is the requester's view and "slave" is the arbiter's view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          req;
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, adr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, adr, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_arb_prio.sv
// Grant decode and fairness state for the two-master arbiter.
// The CPU wins contention until the DMA port has been refused MAX_WAIT times in a row.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [0:0]    ST_PRI_CPU = PRI_CPU;
    localparam logic [0:0]    ST_PRI_DMA = PRI_DMA;
    // Count value at which the current denial is the MAX_WAIT-th one.
    localparam logic [CW-1:0] WAIT_LAST  = CW'(MAX_WAIT - 1);

    logic [0:0]    state_r;
    logic [0:0]    state_nx_s;
    logic [CW-1:0] wait_cnt_r;
    logic [CW-1:0] wait_nx_s;

    // Grant decode: never both grants, nothing granted while in reset.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            case ({req1, req0})
                2'b01: gnt0 = 1'b1;
                2'b10: gnt1 = 1'b1;
                2'b11: begin
                    if (state_r == ST_PRI_DMA) begin
                        gnt1 = 1'b1;
                    end else begin
                        gnt0 = 1'b1;
                    end
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end else begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    // Fairness next-state: count refused DMA cycles, hand priority over after MAX_WAIT.
    always_comb begin
        state_nx_s = state_r;
        wait_nx_s  = wait_cnt_r;
        case (state_r)
            ST_PRI_CPU: begin
                if (req1 && !gnt1) begin
                    if (wait_cnt_r == WAIT_LAST) begin
                        state_nx_s = ST_PRI_DMA;
                        wait_nx_s  = {CW{1'b0}};
                    end else begin
                        state_nx_s = ST_PRI_CPU;
                        wait_nx_s  = wait_cnt_r + CW'(1);
                    end
                end else begin
                    state_nx_s = ST_PRI_CPU;
                    wait_nx_s  = {CW{1'b0}};
                end
            end
            ST_PRI_DMA: begin
                wait_nx_s = {CW{1'b0}};
                // Leave once DMA is served or has withdrawn its request.
                if (!req1 || gnt1) begin
                    state_nx_s = ST_PRI_CPU;
                end else begin
                    state_nx_s = ST_PRI_DMA;
                end
            end
            default: begin
                state_nx_s = ST_PRI_CPU;
                wait_nx_s  = {CW{1'b0}};
            end
        endcase
    end

    // Fairness state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_PRI_CPU;
            wait_cnt_r <= {CW{1'b0}};
        end else begin
            state_r    <= state_nx_s;
            wait_cnt_r <= wait_nx_s;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master arbiter for the unified instruction/data memory: one access per cycle,
// registered onto the memory port, read data returned to the owner one cycle later.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  m0,
    mem_arbiter_if.slave  m1,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    logic          gnt0_s;
    logic          gnt1_s;
    logic          acc_s;
    logic          sel_id_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_adr_s;
    logic [DW-1:0] sel_wd_s;
    logic          rsp_rd_s;

    logic          acc_vld_r;
    logic          acc_id_r;
    logic          acc_we_r;
    logic [AW-1:0] mem_adr_r;
    logic [DW-1:0] mem_wd_r;
    logic          m0_rvalid_r;
    logic          m1_rvalid_r;
    logic [DW-1:0] m0_rdata_r;
    logic [DW-1:0] m1_rdata_r;

    mem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk   (clk),
        .reset (reset),
        .req0  (m0.req),
        .req1  (m1.req),
        .gnt0  (gnt0_s),
        .gnt1  (gnt1_s)
    );

    // Select the winning master's request fields.
    always_comb begin
        acc_s = gnt0_s | gnt1_s;
        if (gnt1_s) begin
            sel_id_s  = M_DMA;
            sel_we_s  = m1.we;
            sel_adr_s = m1.adr;
            sel_wd_s  = m1.wdata;
        end else begin
            sel_id_s  = M_CPU;
            sel_we_s  = m0.we;
            sel_adr_s = m0.adr;
            sel_wd_s  = m0.wdata;
        end
    end

    // Access stage: latch the accepted request onto the memory port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc_vld_r <= 1'b0;
            acc_id_r  <= M_CPU;
            acc_we_r  <= 1'b0;
            mem_adr_r <= {AW{1'b0}};
            mem_wd_r  <= {DW{1'b0}};
        end else begin
            acc_vld_r <= acc_s;
            if (acc_s) begin
                acc_id_r  <= sel_id_s;
                acc_we_r  <= sel_we_s;
                mem_adr_r <= sel_adr_s;
                mem_wd_r  <= sel_wd_s;
            end else begin
                acc_id_r  <= acc_id_r;
                acc_we_r  <= acc_we_r;
                mem_adr_r <= mem_adr_r;
                mem_wd_r  <= mem_wd_r;
            end
        end
    end

    assign rsp_rd_s = acc_vld_r & ~acc_we_r;

    // Response stage: capture read data for the master that issued the read.
    always_ff @(posedge clk) begin
        if (!reset) begin
            m0_rvalid_r <= 1'b0;
            m1_rvalid_r <= 1'b0;
            m0_rdata_r  <= {DW{1'b0}};
            m1_rdata_r  <= {DW{1'b0}};
        end else begin
            m0_rvalid_r <= rsp_rd_s & (acc_id_r == M_CPU);
            m1_rvalid_r <= rsp_rd_s & (acc_id_r == M_DMA);
            if (rsp_rd_s && (acc_id_r == M_CPU)) begin
                m0_rdata_r <= mem_rd;
            end else begin
                m0_rdata_r <= m0_rdata_r;
            end
            if (rsp_rd_s && (acc_id_r == M_DMA)) begin
                m1_rdata_r <= mem_rd;
            end else begin
                m1_rdata_r <= m1_rdata_r;
            end
        end
    end

    // A write accepted just before reset must never reach the memory.
    assign mem_we    = acc_vld_r & acc_we_r & reset;
    assign mem_adr   = mem_adr_r;
    assign mem_wd    = mem_wd_r;

    assign m0.gnt    = gnt0_s;
    assign m1.gnt    = gnt1_s;
    assign m0.rvalid = m0_rvalid_r;
    assign m1.rvalid = m1_rvalid_r;
    assign m0.rdata  = m0_rdata_r;
    assign m1.rdata  = m1_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a reference model predicts grants, memory writes and
// read responses from the arbitration rules; a monitor matches responses as they appear.
module tb_mem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wd;
    logic          mem_we;
    logic [DW-1:0] mem_rd;

    logic          req [2];
    logic          we  [2];
    logic [AW-1:0] adr [2];
    logic [DW-1:0] wd  [2];

    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];

    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    int            streak = 0;
    logic          taken [2];
    logic          pw_vld = 1'b0;
    logic [AW-1:0] pw_adr;
    logic [DW-1:0] pw_data;

    mem_arbiter_if #(.AW(AW), .DW(DW)) m0_if ();
    mem_arbiter_if #(.AW(AW), .DW(DW)) m1_if ();

    assign m0_if.req   = req[0];
    assign m0_if.we    = we[0];
    assign m0_if.adr   = adr[0];
    assign m0_if.wdata = wd[0];
    assign m1_if.req   = req[1];
    assign m1_if.we    = we[1];
    assign m1_if.adr   = adr[1];
    assign m1_if.wdata = wd[1];

    mem_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .m0      (m0_if),
        .m1      (m1_if),
        .mem_adr (mem_adr),
        .mem_wd  (mem_wd),
        .mem_we  (mem_we),
        .mem_rd  (mem_rd)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: combinational read, write committed on the edge where mem_we is high.
    assign mem_rd = mem[mem_adr[9:2]];
    initial forever begin
        @(posedge clk);
        if (mem_we === 1'b1) mem[mem_adr[9:2]] = mem_wd;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int m, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[m] = 1'b1;
        we[m]  = w;
        adr[m] = a;
        wd[m]  = d;
    endtask

    task automatic rand_req(input int m, input bit rd_only);
        issue(m, rd_only ? 1'b0 : 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 15)) << 2, $urandom);
    endtask

    // Reference model: the CPU wins contention unless the DMA port has already been
    // refused MAX_WAIT consecutive requesting cycles; memory is updated in grant order.
    initial begin : model
        logic e0, e1;
        int   g;
        exp_t x;
        forever begin
            @(negedge clk);
            checks++;
            if (mem_we !== (pw_vld & reset)) begin
                errors++;
                $display("FAIL mem_we: got %b expected %b (cycle %0d)", mem_we, pw_vld & reset, cyc);
            end
            if (pw_vld && reset) begin
                checks++;
                if (mem_adr !== pw_adr || mem_wd !== pw_data) begin
                    errors++;
                    $display("FAIL mem_write: got %h/%h expected %h/%h (cycle %0d)",
                             mem_adr, mem_wd, pw_adr, pw_data, cyc);
                end
                ref_mem[pw_adr[9:2]] = pw_data;
            end
            pw_vld = 1'b0;
            if (reset !== 1'b1) begin
                e0     = 1'b0;
                e1     = 1'b0;
                streak = 0;
                if (sbq.size() > 0 && sbq[$].due == cyc + 1) void'(sbq.pop_back());
            end else begin
                e1     = req[1] && (!req[0] || streak >= MAX_WAIT);
                e0     = req[0] && !e1;
                streak = (req[1] && !e1) ? streak + 1 : 0;
            end
            checks++;
            if (m0_if.gnt !== e0 || m1_if.gnt !== e1) begin
                errors++;
                $display("FAIL gnt: got %b%b expected %b%b (cycle %0d)", m1_if.gnt, m0_if.gnt, e1, e0, cyc);
            end
            taken[0] = e0;
            taken[1] = e1;
            if (e0 || e1) begin
                g = e1 ? 1 : 0;
                if (we[g]) begin
                    pw_vld  = 1'b1;
                    pw_adr  = adr[g];
                    pw_data = wd[g];
                end else begin
                    x.id   = e1;
                    x.data = ref_mem[adr[g][9:2]];
                    x.due  = cyc + 2;
                    sbq.push_back(x);
                end
            end
        end
    end

    // Monitor: every rvalid must match the oldest expected response, on its due cycle.
    initial begin : monitor
        exp_t          e;
        logic          aid;
        logic [DW-1:0] adata;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                e = sbq.pop_front();
                checks++;
                errors++;
                $display("FAIL rvalid_missing: got none expected m%0d data %h due %0d", e.id, e.data, e.due);
            end
            if (m0_if.rvalid === 1'b1 || m1_if.rvalid === 1'b1) begin
                checks++;
                if (m0_if.rvalid === 1'b1 && m1_if.rvalid === 1'b1) begin
                    errors++;
                    $display("FAIL rvalid_both: got both rvalids expected one (cycle %0d)", cyc);
                end else if (sbq.size() == 0 || sbq[0].due != cyc) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got m0=%b m1=%b expected none (cycle %0d)",
                             m0_if.rvalid, m1_if.rvalid, cyc);
                end else begin
                    e     = sbq.pop_front();
                    aid   = m1_if.rvalid;
                    adata = aid ? m1_if.rdata : m0_if.rdata;
                    if (aid !== e.id || adata !== e.data) begin
                        errors++;
                        $display("FAIL rdata: got m%0d %h expected m%0d %h (cycle %0d)",
                                 aid, adata, e.id, e.data, cyc);
                    end
                end
            end
        end
    end

    initial begin : stim
        int            n;
        int            den;
        logic [9:0]    pat;
        logic [DW-1:0] old;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        taken[0] = 1'b0;
        taken[1] = 1'b0;

        // Reset held with both masters requesting.
        reset = 1'b0;
        issue(0, 1'b0, 32'h0000_0010, 32'h0);
        issue(1, 1'b1, 32'h0000_0020, 32'h1111_1111);
        tick();
        tick();
        chk("rst_gnt0",    m0_if.gnt,    64'd0);
        chk("rst_gnt1",    m1_if.gnt,    64'd0);
        chk("rst_mem_we",  mem_we,       64'd0);
        chk("rst_rvalid0", m0_if.rvalid, 64'd0);
        chk("rst_rvalid1", m1_if.rvalid, 64'd0);
        chk("rst_mem_adr", mem_adr,      64'd0);
        chk("rst_rdata0",  m0_if.rdata,  64'd0);
        req[0] = 1'b0;
        req[1] = 1'b0;
        reset  = 1'b1;
        tick();

        // CPU write then read-back of the same word on the next cycle.
        issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
        tick();
        issue(0, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        req[0] = 1'b0;
        tick();
        chk("raw_rvalid0", m0_if.rvalid, 64'd1);
        chk("raw_rdata0",  m0_if.rdata,  64'hDEAD_BEEF);
        tick();
        tick();

        // Continuous contention from a fresh reset: DMA wins every fifth cycle.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        pat = 10'd0;
        for (int i = 0; i < 10; i++) begin
            #3;
            pat = {pat[8:0], m1_if.gnt};
            tick();
            for (int m = 0; m < 2; m++) if (taken[m]) rand_req(m, 1'b1);
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        chk("contention_pattern", pat, 64'b00_0010_0001);
        tick();
        tick();

        // DMA alone: eight back-to-back reads 0x00..0x1C.
        n = 0;
        issue(1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            #3;
            n += int'(m1_if.gnt);
            tick();
            if (i < 7) issue(1, 1'b0, AW'((i + 1) * 4), 32'h0);
            else       req[1] = 1'b0;
        end
        chk("dma_burst_gnts", n, 64'd8);
        tick();
        tick();

        // Write accepted, then reset on the following edge: the write is dropped.
        old = mem[32];
        issue(0, 1'b1, 32'h0000_0080, 32'h1234_5678);
        tick();
        req[0] = 1'b0;
        reset  = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("dropped_write", mem[32], {32'd0, old});

        // DMA refused three times, withdraws, then needs four fresh refusals to win.
        rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (taken[0]) rand_req(0, 1'b1);
        end
        req[1] = 1'b0;
        tick();
        if (taken[0]) rand_req(0, 1'b1);
        rand_req(1, 1'b1);
        den = 0;
        for (int i = 0; i < 10; i++) begin
            #3;
            if (m1_if.gnt === 1'b1) break;
            den++;
            tick();
            if (taken[0]) rand_req(0, 1'b1);
        end
        chk("dma_denials_after_drop", den, 64'd4);
        tick();
        req[0] = 1'b0;
        req[1] = 1'b0;
        tick();
        tick();

        // Random traffic: mixed reads/writes, DMA withdrawals, occasional reset pulses.
        for (int i = 0; i < 600; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!req[m] || taken[m]) begin
                    if ($urandom_range(0, 99) < 60) rand_req(m, 1'b0);
                    else                            req[m] = 1'b0;
                end else if (m == 1 && $urandom_range(0, 99) < 5) begin
                    req[1] = 1'b0;
                end
            end
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            tick();
        end
        req[0] = 1'b0;
        req[1] = 1'b0;
        reset  = 1'b1;
        repeat (5) tick();
        chk("scoreboard_drained", sbq.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
